skip_seq_ctrl: RTL
==================

Name: skip_seq_ctrl

Overview:
- Run-controller for the skip-multiples counter datapath.
- On a start command it latches a skip modulus and an upper limit, then emits every value in 1..limit that is not a multiple of the modulus, one per accepted valid/ready beat.
- Signals completion, and tracks residues incrementally, so no divider is needed.
- Sits between a configuration/CSR front end and any consumer of the filtered count stream.

Parameters:
- WIDTH, 4: bit width of values, modulus and limit.
- CNT_W, 5: width of the emitted-value counter. Must satisfy CNT_W >= WIDTH+1.

Ports:
- clk  in  1  clock
- rst  in  1  reset; rst, synchronous, active-high; clock clk
- start  in  1  start request; sampled only in IDLE
- abort  in  1  abandon the current run
- cfg_mod  in  WIDTH  skip modulus m; latched on start
- cfg_limit  in  WIDTH  inclusive upper bound L; latched on start
- out_valid  out  1  out_value is valid
- out_ready  in  1  consumer accepts out_value
- out_value  out  WIDTH  current sequence value
- busy  out  1  high in RUN and DONE
- done  out  1  one-cycle pulse at normal run completion
- err  out  1  one-cycle pulse when start is rejected
- count  out  CNT_W  number of values accepted in the current or last run

Behaviour:
- Reset values: state=IDLE; out_valid=0, out_value=0, busy=0, done=0, err=0, count=0; internal residue=0.
- States: IDLE, RUN, DONE.
- IDLE, on start with m<2: err=1 for one cycle; stay in IDLE; count unchanged.
- IDLE, on start with m>=2 and L=0: latch config; go to DONE; count=0.
- IDLE, on start with m>=2 and L>=1: latch m and L; count=0.
  - Next cycle: RUN with out_value=1, residue=1, out_valid=1.
  - Value 0 is never emitted.
- RUN, holding: out_valid stays 1. out_value is stable while out_ready=0 (AXI-style: valid never drops without a handshake, except on abort or rst).
- RUN, on handshake (out_valid & out_ready): count+1. Compute next in WIDTH+1 bits:
  - If residue==m-1: next=value+2, residue<=1 (skips the multiple of m).
  - Otherwise: next=value+1, residue<=residue+1.
  - If next>L: go to DONE with out_valid=0. No wrap-around is ever emitted; e.g. WIDTH=4, L=15, value=14, m=3 gives next=16 and the run ends.
  - Otherwise: out_value<=next[WIDTH-1:0].
- DONE: done=1 for exactly one cycle, busy=1, then IDLE.
- start while busy is ignored. Config inputs are ignored outside IDLE.
- abort in RUN or DONE: go to IDLE next cycle; out_valid=0; no done pulse; count holds.
- abort has priority over a same-cycle handshake; that beat is not counted.
- abort and start together in IDLE: start is processed and abort is ignored.
- rst mid-run: all outputs return to reset values on the next edge.
- Latency: first valid appears 1 cycle after start is sampled. Throughput is 1 value/cycle when out_ready=1.

Decomposition:
- Shared package skip_pkg holds:
  - state enum {IDLE, RUN, DONE}
  - localparam MIN_MOD=2
  - default WIDTH
- One natural sub-module: skip_step. It is combinational: inputs are value, residue, m and L; outputs are next_value, next_residue, last.
- skip_seq_ctrl holds the FSM, config registers, handshake logic and count.

Test Plan:
- m=3, L=15, out_ready=1 -> out_value sequence 1,2,4,5,7,8,10,11,13,14; then done pulse; count=10; no value 0 or 15; no wrap.
- m=2, L=9, out_ready toggling 1,0,1,0 -> values 1,3,5,7,9; each value held stable while ready=0; count=5; done only after 9 is accepted.
- m=1 and m=0 starts -> err pulse each; state stays IDLE; out_valid never rises.
- m=5, L=0 -> no out_valid; done pulse 1 cycle after start; count=0.
- m=3, L=15: abort after 4 accepted values (abort in the same cycle as the 5th handshake) -> count=4; no done pulse; IDLE next cycle. A new start then restarts at 1.
- rst asserted mid-run with out_ready=1 -> next cycle all outputs at reset values. start during RUN -> ignored and the sequence continues unchanged.

Source files
------------

// File: rtl/skip_seq_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : skip_pkg
//  Description : Shared types and constants for the skip-multiples run control.
//  Revision    : 1.0 - initial release
// ============================================================================
package skip_pkg;

    localparam int DEFAULT_WIDTH = 4;
    localparam int MIN_MOD       = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage : skip_pkg
`default_nettype wire

// File: rtl/skip_seq_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : skip_seq_ctrl_if
//  Description : Valid/ready stream carrying the filtered count values.
//  Revision    : 1.0 - initial release
// ============================================================================
interface skip_seq_ctrl_if
    import skip_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);

    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_value;

    modport master (
        output out_valid,
        output out_value,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_value,
        output out_ready
    );

endinterface : skip_seq_ctrl_if
`default_nettype wire

// File: rtl/skip_seq_ctrl_step.sv
`default_nettype none
// ============================================================================
//  Module      : skip_step
//  Description : Combinational next-value step using an incremental residue.
//  Revision    : 1.0 - initial release
// ============================================================================
module skip_step
    import skip_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] value,
    input  logic [WIDTH-1:0] residue,
    input  logic [WIDTH-1:0] m,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] next_value,
    output logic [WIDTH-1:0] next_residue,
    output logic             last
);

    logic             at_pre_mult;
    logic [WIDTH:0]   wide_next;

    // One extra bit keeps value+2 from wrapping so the limit compare stays exact.
    always_comb begin
        at_pre_mult  = (residue == (m - WIDTH'(1)));
        wide_next    = {1'b0, value} + (at_pre_mult ? (WIDTH+1)'(2) : (WIDTH+1)'(1));
        next_residue = at_pre_mult ? WIDTH'(1) : (residue + WIDTH'(1));
        next_value   = wide_next[WIDTH-1:0];
        last         = (wide_next > {1'b0, limit});
    end

endmodule : skip_step
`default_nettype wire

// File: rtl/skip_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : skip_seq_ctrl
//  Description : Emits 1..limit skipping multiples of the modulus on a stream.
//  Revision    : 1.0 - initial release
// ============================================================================
module skip_seq_ctrl
    import skip_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                abort,
    input  logic [WIDTH-1:0]    cfg_mod,
    input  logic [WIDTH-1:0]    cfg_limit,
    skip_seq_ctrl_if.master     strm,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic [CNT_W-1:0]    count
);

    state_e           state_q,   state_d;
    logic [WIDTH-1:0] mod_q,     mod_d;
    logic [WIDTH-1:0] limit_q,   limit_d;
    logic [WIDTH-1:0] value_q,   value_d;
    logic [WIDTH-1:0] residue_q, residue_d;
    logic             valid_q,   valid_d;
    logic             busy_q,    busy_d;
    logic             done_q,    done_d;
    logic             err_q,     err_d;
    logic [CNT_W-1:0] count_q,   count_d;

    logic [WIDTH-1:0] step_value;
    logic [WIDTH-1:0] step_residue;
    logic             step_last;
    logic             handshake;

    skip_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .value        (value_q),
        .residue      (residue_q),
        .m            (mod_q),
        .limit        (limit_q),
        .next_value   (step_value),
        .next_residue (step_residue),
        .last         (step_last)
    );

    always_comb begin
        state_d   = state_q;
        mod_d     = mod_q;
        limit_d   = limit_q;
        value_d   = value_q;
        residue_d = residue_q;
        valid_d   = valid_q;
        count_d   = count_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        handshake = valid_q & strm.out_ready;

        unique case (state_q)
            IDLE: begin
                // abort carries no meaning here, so a coincident start wins.
                if (start) begin
                    if (cfg_mod < WIDTH'(MIN_MOD)) begin
                        err_d = 1'b1;
                    end else begin
                        mod_d   = cfg_mod;
                        limit_d = cfg_limit;
                        count_d = '0;
                        if (cfg_limit == '0) begin
                            state_d = DONE;
                            done_d  = 1'b1;
                        end else begin
                            state_d   = RUN;
                            value_d   = WIDTH'(1);
                            residue_d = WIDTH'(1);
                            valid_d   = 1'b1;
                        end
                    end
                end
            end
            RUN: begin
                if (abort) begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                end else if (handshake) begin
                    count_d = count_q + CNT_W'(1);
                    if (step_last) begin
                        state_d = DONE;
                        valid_d = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        value_d   = step_value;
                        residue_d = step_residue;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            mod_q     <= '0;
            limit_q   <= '0;
            value_q   <= '0;
            residue_q <= '0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            mod_q     <= mod_d;
            limit_q   <= limit_d;
            value_q   <= value_d;
            residue_q <= residue_d;
            valid_q   <= valid_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
            count_q   <= count_d;
        end
    end

    assign strm.out_valid = valid_q;
    assign strm.out_value = value_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign err            = err_q;
    assign count          = count_q;

endmodule : skip_seq_ctrl
`default_nettype wire
